// File: rtl/fetch_cur_chroma_loader.sv
// rtl/fetch_cur_chroma_loader.sv - fetches one LCU's U/V chroma rows (two 16-sample beats each) into the current-LCU buffer
module fetch_cur_chroma_loader #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      sysif_start_i,
  input  logic [7:0]                sysif_lcu_x_i,
  input  logic [7:0]                sysif_lcu_y_i,
  output logic                      extif_req_o,
  input  logic                      extif_ack_i,
  output logic [7:0]                extif_lcu_x_o,
  output logic [7:0]                extif_lcu_y_o,
  output logic                      extif_sel_o,
  output logic [4:0]                extif_row_o,
  input  logic                      extif_valid_i,
  input  logic [16*PIXEL_WIDTH-1:0] extif_data_i,
  output logic                      ext_load_valid_o,
  output logic [5:0]                ext_load_addr_o,
  output logic [32*PIXEL_WIDTH-1:0] ext_load_data_o,
  output logic                      ext_load_done_o,
  output logic                      busy_o
);

  localparam int HALF_W = 16 * PIXEL_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BEAT0,
    ST_BEAT1,
    ST_DONE
  } state_e;

  state_e                    state_q;
  logic [5:0]                cnt_q;      // {sel, row}: U rows 0..31 then V rows 0..31
  logic [7:0]                lcu_x_q;
  logic [7:0]                lcu_y_q;
  logic [HALF_W-1:0]         hi_q;       // first beat of the row being assembled
  logic                      req_q;
  logic                      load_valid_q;
  logic [5:0]                load_addr_q;
  logic [32*PIXEL_WIDTH-1:0] load_data_q;
  logic                      done_q;

  // Control FSM with all outputs registered; the write strobe for a row and the
  // request for the next row leave in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 6'd0;
      lcu_x_q      <= 8'd0;
      lcu_y_q      <= 8'd0;
      hi_q         <= '0;
      req_q        <= 1'b0;
      load_valid_q <= 1'b0;
      load_addr_q  <= 6'd0;
      load_data_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sysif_start_i) begin
            lcu_x_q <= sysif_lcu_x_i;
            lcu_y_q <= sysif_lcu_y_i;
            cnt_q   <= 6'd0;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (extif_ack_i) begin
            req_q   <= 1'b0;
            state_q <= ST_BEAT0;
          end
        end
        ST_BEAT0: begin
          if (extif_valid_i) begin
            hi_q    <= extif_data_i;
            state_q <= ST_BEAT1;
          end
        end
        ST_BEAT1: begin
          if (extif_valid_i) begin
            load_valid_q <= 1'b1;
            load_addr_q  <= cnt_q;
            load_data_q  <= {hi_q, extif_data_i};
            if (cnt_q == 6'd63) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              cnt_q   <= cnt_q + 6'd1;
              req_q   <= 1'b1;
              state_q <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign extif_req_o      = req_q;
  assign extif_lcu_x_o    = lcu_x_q;
  assign extif_lcu_y_o    = lcu_y_q;
  assign extif_sel_o      = cnt_q[5];
  assign extif_row_o      = cnt_q[4:0];
  assign ext_load_valid_o = load_valid_q;
  assign ext_load_addr_o  = load_addr_q;
  assign ext_load_data_o  = load_data_q;
  assign ext_load_done_o  = done_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule
